// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, default word width and
// {CKP,CPH} mode constants used by the transmitter, receiver and benches.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 16;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise and
// fall pulses taken against one extra flop behind the synchronized value.
module spi_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{rst_val}};
            prev_q <= rst_val;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_receptor_sync.sv
// clk-domain SPI slave: oversampled SCK/CS/MOSI, one DATA_W word per CS frame.
// Define SPI_ECHO_EN to reload tx_buf with each received word.
module spi_receptor_sync
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned     CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic mosi_s, leading, trailing, sample_edge, shift_edge;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              first_q, first_d;
    logic              done_q, done_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .reset(reset), .rst_val(CKP), .d(SCK),
        .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset(reset), .rst_val(1'b1), .d(CS),
        .rise(cs_rise), .fall(cs_fall)
    );

    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    assign leading     = CKP ? sck_fall : sck_rise;
    assign trailing    = CKP ? sck_rise : sck_fall;
    assign sample_edge = CPH ? trailing : leading;
    assign shift_edge  = CPH ? leading  : trailing;

    always_comb begin
        state_d     = state_q;
        tx_buf_d    = tx_buf_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        first_d     = first_q;
        done_d      = 1'b0;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (tx_load) begin
            tx_buf_d = tx_data;
`ifdef SPI_ECHO_EN
        end else if (rx_valid_q) begin
            tx_buf_d = rx_data_q;
`endif
        end

        // Word is published one cycle after the final sample lands in rx_sh.
        if (done_q) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    tx_sh_d   = tx_load ? tx_data : tx_buf_q;
                    bit_cnt_d = '0;
                    first_d   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (sample_edge) begin
                    rx_sh_d   = {rx_sh_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (shift_edge) begin
                    // CPH=1: the first leading edge only presents the MSB.
                    if (CPH && first_q) begin
                        first_d = 1'b0;
                    end else begin
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            tx_buf_q    <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            tx_buf_q    <= tx_buf_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            done_q      <= done_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign busy      = (state_q == ST_ACTIVE);
    assign MISO      = busy & tx_sh_q[DATA_W-1];
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_receptor_sync.sv
// Directed bench for spi_receptor_sync: bench-side SPI master at clk/8 in all
// four modes, abort, mid-frame tx_load, mid-frame reset and (SPI_ECHO_EN) echo.
module tb_spi_receptor_sync;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        reset, CKP, CPH, SCK, CS, MOSI, MISO;
    logic [15:0] tx_data, rx_data;
    logic        tx_load, rx_valid, busy, frame_err;

    int errors = 0;
    int checks = 0;
    int rxv_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    spi_receptor_sync #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
        .MOSI(MOSI), .MISO(MISO), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (rx_valid)  rxv_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] w);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        CKP = m[1];
        CPH = m[0];
        SCK = m[1];
        repeat (4) @(negedge clk);
    endtask

    task automatic half_wait(input logic ld, input logic [15:0] lw);
        if (ld) begin
            tx_data = lw;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    // Master side: half SCK period = 4 clk; MISO read just before the sampling pin edge.
    task automatic spi_frame(input logic [15:0] w, input int nbits, input logic ld,
                             input logic [15:0] lw, output logic [15:0] r);
        r  = '0;
        CS = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (CPH) SCK = ~CKP;
            MOSI = w[15-i];
            half_wait(ld && (i == 8), lw);
            if (i == 8) chk("busy_mid", busy, 1);
            r[15-i] = MISO;
            SCK = CPH ? CKP : ~CKP;
            repeat (4) @(negedge clk);
            if (!CPH) SCK = CKP;
        end
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
        CS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] r;
        int nv, ne;

        reset = 1'b1; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
        tx_data = '0; tx_load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_miso", MISO, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);

        // mode 0 basic exchange
        load(16'hA5C3);
        nv = rxv_cnt;
        spi_frame(16'h1234, 16, 1'b0, '0, r);
        chk("m0_rx_data", rx_data, 16'h1234);
        chk("m0_rx_valid_cnt", rxv_cnt - nv, 1);
        chk("m0_miso", r, 16'hA5C3);
        chk("m0_busy_end", busy, 0);

        for (int m = 1; m < 4; m++) begin
            logic [1:0] md;
            md = m[1:0];
            set_mode(md);
            load(16'h0F0F);
            nv = rxv_cnt;
            spi_frame(16'hBEEF, 16, 1'b0, '0, r);
            chk($sformatf("mode%0d_rx_data", m), rx_data, 16'hBEEF);
            chk($sformatf("mode%0d_rx_valid_cnt", m), rxv_cnt - nv, 1);
            chk($sformatf("mode%0d_miso", m), r, 16'h0F0F);
            chk($sformatf("mode%0d_busy_end", m), busy, 0);
        end

        // aborted frame after 7 bits
        set_mode(MODE0);
        nv = rxv_cnt; ne = err_cnt;
        spi_frame(16'hFFFF, 7, 1'b0, '0, r);
        chk("abort_frame_err_cnt", err_cnt - ne, 1);
        chk("abort_rx_valid_cnt", rxv_cnt - nv, 0);
        chk("abort_rx_data_hold", rx_data, 16'hBEEF);
        chk("abort_busy", busy, 0);
        spi_frame(16'h0001, 16, 1'b0, '0, r);
        chk("after_abort_rx_data", rx_data, 16'h0001);

        // tx_load while a frame is shifting out
        load(16'hAAAA);
        spi_frame(16'h3C3C, 16, 1'b1, 16'h5555, r);
        chk("midload_cur_miso", r, 16'hAAAA);
        chk("midload_rx_data", rx_data, 16'h3C3C);
        spi_frame(16'h0F0F, 16, 1'b0, '0, r);
`ifdef SPI_ECHO_EN
        chk("midload_next_miso", r, 16'h3C3C);
`else
        chk("midload_next_miso", r, 16'h5555);
`endif
        chk("midload_next_rx", rx_data, 16'h0F0F);

        // reset pulsed in the middle of a frame
        nv = rxv_cnt; ne = err_cnt;
        CS = 1'b0;
        repeat (8) @(negedge clk);
        MOSI = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat (4) @(negedge clk);
            SCK = 1'b1;
            repeat (4) @(negedge clk);
            SCK = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1; CS = 1'b1; SCK = CKP; MOSI = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_miso", MISO, 0);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_no_valid", rxv_cnt - nv, 0);
        chk("midrst_no_err", err_cnt - ne, 0);
        spi_frame(16'hC0DE, 16, 1'b0, '0, r);
        chk("after_rst_rx_data", rx_data, 16'hC0DE);

`ifdef SPI_ECHO_EN
        spi_frame(16'h1111, 16, 1'b0, '0, r);
        spi_frame(16'h2222, 16, 1'b0, '0, r);
        chk("echo_miso", r, 16'h1111);
        chk("echo_rx_data", rx_data, 16'h2222);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
